// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Upstream control stage for a 2**SEL_W:1 mux. Accepts one DATA_W-bit word
//   over a valid/ready handshake, presents it on mux_in and sweeps sel through
//   every mux position, holding each position for HOLD cycles, so that the mux
//   output carries the word serially. A frame is marked by a one-cycle
//   frame_start (first position live) and a one-cycle frame_done (normal
//   completion). An abort (stop) returns to IDLE without frame_done.
//
//   Build option:
//     MUX_SEL_DESCEND_EN - when defined, the sweep runs from the top position
//                          down to 0 (MSB-first). Timing, handshake, abort and
//                          pulse behaviour are the same as the ascending build.
//
//   Constraints: DATA_W must equal 2**SEL_W; HOLD must be in 1..255.
module mux_sel_sequencer #(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 16,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              stop,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  // Hold counter is sized for the largest legal HOLD (255).
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

  // First and last mux position of a frame, depending on sweep direction.
`ifdef MUX_SEL_DESCEND_EN
  localparam logic [SEL_W-1:0] SEL_FIRST = '1;
  localparam logic [SEL_W-1:0] SEL_LAST  = '0;
`else
  localparam logic [SEL_W-1:0] SEL_FIRST = '0;
  localparam logic [SEL_W-1:0] SEL_LAST  = '1;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mux_in_q, mux_in_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_valid_q, sel_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;

  // Next mux position in the sweep direction. Never called on SEL_LAST, so
  // it cannot wrap; the wrap back to 0 only happens on the return to IDLE.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s);
`ifdef MUX_SEL_DESCEND_EN
    sel_step = s - SEL_W'(1);
`else
    sel_step = s + SEL_W'(1);
`endif
  endfunction

  // State and output registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mux_in_q      <= '0;
      sel_q         <= '0;
      cnt_q         <= '0;
      sel_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mux_in_q      <= mux_in_d;
      sel_q         <= sel_d;
      cnt_q         <= cnt_d;
      sel_valid_q   <= sel_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Next-state logic: accept in IDLE, hold/advance/finish or abort in SCAN.
  always_comb begin
    state_d       = state_q;
    mux_in_d      = mux_in_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    sel_valid_d   = sel_valid_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // load_ready is high throughout IDLE, so valid alone means accept.
        // stop has no meaning here and is ignored.
        if (load_valid) begin
          mux_in_d      = load_data;
          sel_d         = SEL_FIRST;
          cnt_d         = '0;
          sel_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        if (stop) begin
          // Abort wins over any advance and produces no frame_done.
          state_d     = IDLE;
          sel_valid_d = 1'b0;
          sel_d       = '0;
          cnt_d       = '0;
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (sel_q == SEL_LAST) begin
            state_d      = IDLE;
            sel_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            sel_d        = '0;
          end else begin
            sel_d = sel_step(sel_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == SCAN);
  assign mux_in      = mux_in_q;
  assign sel         = sel_q;
  assign sel_valid   = sel_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two instances (HOLD=1 and HOLD=3) driven by
// directed sequences followed by random traffic, checked every cycle against
// a frame-age model plus literal expectations at key points.
module tb_mux_sel_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        lv  [2];
  logic [15:0] ld  [2];
  logic        stp [2];
  logic        lr  [2];
  logic [15:0] mi  [2];
  logic [3:0]  sl  [2];
  logic        sv  [2];
  logic        fs  [2];
  logic        fd  [2];
  logic        bz  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer #(.SEL_W(4), .DATA_W(16), .HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0]), .stop(stp[0]), .mux_in(mi[0]), .sel(sl[0]),
    .sel_valid(sv[0]), .frame_start(fs[0]), .frame_done(fd[0]), .busy(bz[0])
  );

  mux_sel_sequencer #(.SEL_W(4), .DATA_W(16), .HOLD(3)) u_dut3 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .stop(stp[1]), .mux_in(mi[1]), .sel(sl[1]),
    .sel_valid(sv[1]), .frame_start(fs[1]), .frame_done(fd[1]), .busy(bz[1])
  );

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: a frame is "active" for 16*HOLD cycles after accept;
  // the position is simply age/HOLD in sweep order.
  bit          m_act   [2] = '{0, 0};
  int          m_age   [2] = '{0, 0};
  logic [15:0] m_word  [2] = '{16'h0, 16'h0};
  bit          m_start [2] = '{0, 0};
  bit          m_done  [2] = '{0, 0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_age[i] = 0; m_word[i] = 16'h0;
        m_start[i] = 0; m_done[i] = 0;
      end else begin
        m_start[i] = 0;
        m_done[i]  = 0;
        if (!m_act[i]) begin
          if (lv[i]) begin
            m_act[i] = 1; m_age[i] = 0; m_word[i] = ld[i]; m_start[i] = 1;
          end
        end else if (stp[i]) begin
          m_act[i] = 0; m_age[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] == 16 * hold_of(i)) begin
            m_act[i] = 0; m_age[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  end

  function automatic int model_sel(input int i);
    int pos;
    if (!m_act[i]) return 0;
    pos = m_age[i] / hold_of(i);
`ifdef MUX_SEL_DESCEND_EN
    return 15 - pos;
`else
    return pos;
`endif
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.load_ready", i),  32'(lr[i]), 32'(!m_act[i]));
      chk($sformatf("u%0d.busy", i),        32'(bz[i]), 32'(m_act[i]));
      chk($sformatf("u%0d.sel_valid", i),   32'(sv[i]), 32'(m_act[i]));
      chk($sformatf("u%0d.sel", i),         32'(sl[i]), 32'(model_sel(i)));
      chk($sformatf("u%0d.mux_in", i),      32'(mi[i]), 32'(m_word[i]));
      chk($sformatf("u%0d.frame_start", i), 32'(fs[i]), 32'(m_start[i]));
      chk($sformatf("u%0d.frame_done", i),  32'(fd[i]), 32'(m_done[i]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_pos(input int k);
`ifdef MUX_SEL_DESCEND_EN
    return 15 - k;
`else
    return k;
`endif
  endfunction

  initial begin
    int n;
    int cnt;
    logic [15:0] w;
    logic bit_exp;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0; ld[i] = 16'h0; stp[i] = 1'b0;
    end

    // Reset, then idle with load_valid low for 5 cycles.
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("rst.load_ready", 32'(lr[0]), 32'd1);
    chk("rst.sel", 32'(sl[0]), 32'd0);
    chk("rst.sel_valid", 32'(sv[0]), 32'd0);
    chk("rst.busy", 32'(bz[0]), 32'd0);
    chk("rst.pulses", 32'({fs[0], fd[0]}), 32'd0);

    // Single frame on the HOLD=1 instance.
`ifdef MUX_SEL_DESCEND_EN
    w = 16'h8001;
`else
    w = 16'h5555;
`endif
    lv[0] = 1'b1; ld[0] = w;
    cyc();
    lv[0] = 1'b0; ld[0] = 16'hDEAD;
    chk("single.frame_start", 32'(fs[0]), 32'd1);
    chk("single.mux_in", 32'(mi[0]), 32'(w));
    for (int k = 0; k < 16; k++) begin
`ifdef MUX_SEL_DESCEND_EN
      bit_exp = (k == 0 || k == 15);
`else
      bit_exp = (k % 2 == 0);
`endif
      chk($sformatf("single.sel_k%0d", k), 32'(sl[0]), 32'(exp_pos(k)));
      chk($sformatf("single.out_k%0d", k), 32'(mi[0][sl[0]]), 32'(bit_exp));
      if (k == 1) chk("single.start_cleared", 32'(fs[0]), 32'd0);
      if (k < 15) cyc();
    end
    cyc();
    chk("single.frame_done", 32'(fd[0]), 32'd1);
    chk("single.sel_valid_off", 32'(sv[0]), 32'd0);
    chk("single.sel_back0", 32'(sl[0]), 32'd0);
    cyc();
    chk("single.done_cleared", 32'(fd[0]), 32'd0);

    // HOLD=3 frame: sel_valid high for 48 cycles, done on cycle 49.
    lv[1] = 1'b1; ld[1] = 16'hA5C3;
    cyc();
    lv[1] = 1'b0;
    n = 0; cnt = 0;
    while (!fd[1] && n < 200) begin
      if (sv[1]) cnt++;
      cyc();
      n++;
    end
    chk("hold3.valid_cycles", 32'(cnt), 32'd48);
    chk("hold3.done_cycle", 32'(n + 1), 32'd49);
    chk("hold3.mux_in", 32'(mi[1]), 32'hA5C3);

    // Back-to-back with load_valid held high.
    lv[0] = 1'b1; ld[0] = 16'h00FF;
    cyc();
    ld[0] = 16'hFF00;
    n = 0;
    while (!fd[0] && n < 100) begin cyc(); n++; end
    chk("b2b.done_seen", 32'(fd[0]), 32'd1);
    chk("b2b.mux_in_kept", 32'(mi[0]), 32'h00FF);
    chk("b2b.ready_in_done", 32'(lr[0]), 32'd1);
    cyc();
    lv[0] = 1'b0;
    chk("b2b.next_start", 32'(fs[0]), 32'd1);
    chk("b2b.next_word", 32'(mi[0]), 32'hFF00);
    n = 0;
    while (!fd[0] && n < 100) begin cyc(); n++; end
    chk("b2b.second_done", 32'(fd[0]), 32'd1);
    cyc();

    // Abort at sel=7.
    lv[0] = 1'b1; ld[0] = 16'h1234;
    cyc();
    lv[0] = 1'b0;
    n = 0;
    while (sl[0] != 4'd7 && n < 100) begin cyc(); n++; end
    chk("abort.reached7", 32'(sl[0]), 32'd7);
    stp[0] = 1'b1;
    cyc();
    stp[0] = 1'b0;
    chk("abort.sel_valid", 32'(sv[0]), 32'd0);
    chk("abort.sel", 32'(sl[0]), 32'd0);
    chk("abort.ready", 32'(lr[0]), 32'd1);
    chk("abort.no_done", 32'(fd[0]), 32'd0);
    cyc();
    chk("abort.no_done_later", 32'(fd[0]), 32'd0);

    // Reset pulse at sel=9: outputs clear immediately.
    lv[0] = 1'b1; ld[0] = 16'hBEEF;
    cyc();
    lv[0] = 1'b0;
    n = 0;
    while (sl[0] != 4'd9 && n < 100) begin cyc(); n++; end
    chk("rstmid.reached9", 32'(sl[0]), 32'd9);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.sel", 32'(sl[0]), 32'd0);
    chk("rstmid.sel_valid", 32'(sv[0]), 32'd0);
    chk("rstmid.mux_in", 32'(mi[0]), 32'd0);
    chk("rstmid.busy", 32'(bz[0]), 32'd0);
    chk("rstmid.pulses", 32'({fs[0], fd[0]}), 32'd0);
    chk("rstmid.ready", 32'(lr[0]), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();

    // Random traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        lv[i]  = ($urandom_range(0, 3) != 0);
        ld[i]  = 16'($urandom);
        stp[i] = ($urandom_range(0, 39) == 0);
      end
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0; stp[i] = 1'b0;
    end
    for (int k = 0; k < 60; k++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
